// File: rtl/fmap_readback_if.sv
// Purpose : output word stream of the feature-map readback block (valid/ready).
// Latency : n/a (signal bundle only).
// Backpressure: the master holds out_data/out_valid/out_last stable while out_ready is low.
// Ports   : out_data  - stream word           (master -> slave)
//           out_valid - word present          (master -> slave)
//           out_last  - final word of window  (master -> slave)
//           out_ready - consumer accepts word (slave -> master)
interface fmap_readback_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fmap_readback.sv
// Purpose : reads a programmable window of the feature-map RAM and streams the words out.
// Latency : first out_valid RD_LAT+1 cycles after an accepted start; then 1 word/cycle.
// Backpressure: reads are issued only against free FIFO space, so a stalled consumer never loses or duplicates words.
// Ports   : clk/rst                  - clock, async active-high reset
//           i_start/i_base_addr/i_word_cnt - readback request (sampled on accepted start)
//           o_ram_addr_rtb/o_ram_en_rtb/i_ram_data_r - synchronous RAM read port
//           o_stream                 - output word stream (fmap_readback_if.master)
//           o_busy/o_done            - status: busy in RUN/DRAIN, one-cycle done pulse
module fmap_readback #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_word_cnt,
    output logic [ADDR_W-1:0] o_ram_addr_rtb,
    output logic              o_ram_en_rtb,
    input  logic [DATA_W-1:0] i_ram_data_r,
    fmap_readback_if.master   o_stream,
    output logic              o_busy,
    output logic              o_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // Wide enough for FIFO count + issue register + every pipe stage.
    localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remain;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [ADDR_W-1:0] r_delivered;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_en;
    logic [RD_LAT-1:0] r_pipe;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occ;
    logic              w_credit;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_last;
    logic [ADDR_W:0]   w_deliv_nxt;

    // Reads in flight = the one sitting in the issue register plus every
    // set pipe stage. Counting the issue register too keeps the credit
    // check safe even though the decision is made from registered state.
    always_comb begin
        w_inflight = OCC_W'(r_ram_en);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + OCC_W'(r_pipe[i]);
        end
    end

    // Pops in the current cycle are ignored here, so the check is
    // conservative: the FIFO can never be over-committed.
    assign w_occ       = OCC_W'(r_count) + w_inflight;
    assign w_credit    = (w_occ < OCC_W'(FIFO_DEPTH));

    assign w_push      = r_pipe[RD_LAT-1];
    assign w_valid     = (r_count != '0);
    assign w_pop       = w_valid && o_stream.out_ready;
    assign w_deliv_nxt = {1'b0, r_delivered} + (ADDR_W+1)'(1);
    assign w_last      = w_valid && (w_deliv_nxt == {1'b0, r_word_cnt});

    assign o_stream.out_data  = r_mem[r_rptr];
    assign o_stream.out_valid = w_valid;
    assign o_stream.out_last  = w_last;
    assign o_ram_addr_rtb     = r_ram_addr;
    assign o_ram_en_rtb       = r_ram_en;
    assign o_busy             = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done             = (r_state == S_DONE);

    // Control FSM and read issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remain    <= '0;
            r_word_cnt  <= '0;
            r_delivered <= '0;
            r_ram_addr  <= '0;
            r_ram_en    <= 1'b0;
        end else begin
            r_ram_en <= 1'b0;
            if (w_pop) begin
                r_delivered <= r_delivered + ADDR_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_word_cnt  <= i_word_cnt;
                        r_delivered <= '0;
                        if (i_word_cnt == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            // The first word goes out on the accepting edge so
                            // data arrives RD_LAT+1 cycles after start. The FIFO
                            // and pipe are always empty in IDLE, so it has credit.
                            r_ram_en   <= 1'b1;
                            r_ram_addr <= i_base_addr;
                            r_addr     <= i_base_addr + ADDR_W'(1);
                            r_remain   <= i_word_cnt - ADDR_W'(1);
                            r_state    <= (i_word_cnt == ADDR_W'(1)) ? S_DRAIN : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_credit) begin
                        r_ram_en   <= 1'b1;
                        r_ram_addr <= r_addr;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_remain   <= r_remain - ADDR_W'(1);
                        if (r_remain == ADDR_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Enable tracker: bit RD_LAT-1 lines up with valid RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= r_ram_en;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Output FIFO; head is read straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_ram_data_r;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
